// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        MEM     = 2'd1,
        BRANCH  = 2'd2,
        LOADUSE = 2'd3
    } stall_cause_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait.sv
// RUN/WAIT handshake FSM for variable-latency data-memory accesses,
// with a wait counter that abandons the access after TIMEOUT-1 wait cycles.
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic acc_i,
    input  logic dmem_ready_i,
    output logic mstall_o,
    output logic dmem_req_o,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mstall_o   = 1'b0;
        dmem_req_o = 1'b0;
        timeout_o  = 1'b0;
        case (state_q)
            RUN: begin
                dmem_req_o = acc_i;
                if (acc_i && !dmem_ready_i) begin
                    mstall_o = 1'b1;
                    state_d  = WAIT;
                    cnt_d    = CNT_ONE;
                end
            end
            WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ready_i) begin
                    state_d = RUN;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: release the pipeline and flag the error upstream.
                    timeout_o = 1'b1;
                    state_d   = RUN;
                end else begin
                    mstall_o = 1'b1;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: memory stall,
// taken-branch flush and load-use bubble, in that priority order.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             mstall, fsm_req, timeout;
    logic             loaduse;
    stall_cause_e     cause;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             mem_err_q, mem_err_d;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait (
        .clk          (clk),
        .rst          (rst),
        .acc_i        (mem_memread | mem_memwrite),
        .dmem_ready_i (dmem_ready),
        .mstall_o     (mstall),
        .dmem_req_o   (fsm_req),
        .timeout_o    (timeout)
    );

    assign loaduse = ex_memread && (ex_rd != REG_ZERO) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        cause = NONE;
        if (mstall)
            cause = MEM;
        else if (branch_taken)
            cause = BRANCH;
        else if (loaduse)
            cause = LOADUSE;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        dmem_req    = 1'b0;
        if (!rst) begin
            dmem_req = fsm_req;
            case (cause)
                MEM: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                end
                BRANCH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                LOADUSE: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        mem_err_d = mem_err_q | timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            mem_err_q      <= 1'b0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the driver pushes model predictions per cycle, the
// monitor compares them against the DUT on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    typedef struct {
        logic [7:0]    ctl;
        logic [CW-1:0] sc;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
    logic          id_uses_rt = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0;
    logic          mem_memread = 1'b0, mem_memwrite = 1'b0, dmem_ready = 1'b0;
    logic          dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, memwb_flush, mem_err;
    logic [CW-1:0] stall_cycles;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference-model state
    bit m_waiting = 0;
    int m_waited  = 0;
    int m_stalls  = 0;
    bit m_err     = 0;

    pipeline_hazard_ctrl #(
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .branch_taken (branch_taken),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .memwb_flush  (memwb_flush),
        .stall_cycles (stall_cycles),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, predict the response, advance one clock.
    task automatic step(input bit r, input int rs, input int rt, input bit urt,
                        input int rd, input bit emr, input bit br,
                        input bit mr, input bit mw, input bit rdy);
        exp_t e;
        bit req, ms, tmo, hz;
        bit pc, fen, ffl, den, dfl, xen, wfl;
        rst = r; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt;
        ex_rd = 5'(rd); ex_memread = emr; branch_taken = br;
        mem_memread = mr; mem_memwrite = mw; dmem_ready = rdy;

        pc = 1; fen = 1; ffl = 0; den = 1; dfl = 0; xen = 1; wfl = 0;
        req = 0; ms = 0; tmo = 0;
        e.sc  = CW'(m_stalls);
        e.err = m_err;
        if (r) begin
            m_waiting = 0; m_waited = 0; m_stalls = 0; m_err = 0;
        end else begin
            if (!m_waiting) begin
                req = mr | mw;
                if (req && !rdy) begin
                    ms = 1; m_waiting = 1; m_waited = 1;
                end
            end else begin
                req = 1;
                if (rdy) m_waiting = 0;
                else if (m_waited == TO - 1) begin tmo = 1; m_waiting = 0; end
                else begin ms = 1; m_waited++; end
            end
            hz = emr && rd != 0 && (rd == rs || (urt && rd == rt));
            if (ms) begin pc = 0; fen = 0; den = 0; xen = 0; wfl = 1; end
            else if (br) begin ffl = 1; dfl = 1; end
            else if (hz) begin pc = 0; fen = 0; dfl = 1; end
            if (!pc && m_stalls < SMAX) m_stalls++;
            if (tmo) m_err = 1;
        end
        e.ctl = {req, pc, fen, ffl, den, dfl, xen, wfl};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e = q.pop_front();
            got = {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, memwb_flush};
            vectors++;
            if (got !== e.ctl || stall_cycles !== e.sc || mem_err !== e.err) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t ctl got %b exp %b stall_cycles got %0d exp %0d mem_err got %b exp %b",
                         vectors, $time, got, e.ctl, stall_cycles, e.sc, mem_err, e.err);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset state
        idle();
        // load-use on rs, then ex_rd=0
        step(0, 5, 0, 0, 5, 1, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // rt match with and without id_uses_rt
        step(0, 1, 7, 0, 7, 1, 0, 0, 0, 0);
        step(0, 1, 7, 1, 7, 1, 0, 0, 0, 0);
        idle();
        // memory wait of 3 cycles, then zero-wait access
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle();
        // timeout on a store, mem_err stays set
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) idle();
        // branch with load-use; branch held through a memory wait
        step(0, 3, 0, 0, 3, 1, 1, 0, 0, 0);
        repeat (2) step(0, 3, 0, 0, 3, 1, 1, 1, 0, 0);
        step(0, 3, 0, 0, 3, 1, 1, 1, 0, 1);
        idle();
        // reset mid-WAIT after 2 wait cycles
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 150) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom % 2 == 0, int'($urandom_range(0, 3)),
                 $urandom % 3 == 0, $urandom % 5 == 0,
                 $urandom % 4 == 0, $urandom % 5 == 0, $urandom % 3 == 0);
        end
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left %0d exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
